// File: rtl/mem_burst_pkg.sv
// Shared types and sizes for the 4-beat x 64-bit burst memory responder.
package mem_burst_pkg;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned LINE_W = BEAT_W * BEATS;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} resp_state_e;
  typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/burst_mem_array.sv
// Word store with one synchronous read port and one synchronous write port.
// Read data is zero on cycles without a read so it can drive a beat bus directly.
module burst_mem_array
  import mem_burst_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  beat_t             wr_data,
  output beat_t             rd_data
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  beat_t mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end
endmodule

// File: rtl/burst_memory_responder.sv
// Memory-side responder: accepts a line request and answers with 4 resp_o beats
// after a fixed latency, backed by burst_mem_array.
module burst_memory_responder
  import mem_burst_pkg::*;
#(
  parameter int unsigned LINE_IDX_W = 6,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] address_i,
  input  beat_t       burst_i,
  output beat_t       burst_o,
  output logic        resp_o,
  output logic        proto_err_o
);
  localparam int unsigned WORD_AW = LINE_IDX_W + BEAT_IDX_W;

  resp_state_e state, state_d;
  logic                  op_write, op_write_d;
  logic [LINE_IDX_W-1:0] line_idx, line_idx_d;
  logic [3:0]            lat_cnt, lat_cnt_d;
  logic [BEAT_IDX_W-1:0] beat_cnt, beat_cnt_d;
  logic [BEAT_IDX_W-1:0] out_beat, out_beat_d;
  logic                  resp_d, err_d;
  logic                  req_held, rd_en, wr_en;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{address_i[31:5+LINE_IDX_W], address_i[4:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_write    <= 1'b0;
      line_idx    <= '0;
      lat_cnt     <= '0;
      beat_cnt    <= '0;
      out_beat    <= '0;
      resp_o      <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      state       <= state_d;
      op_write    <= op_write_d;
      line_idx    <= line_idx_d;
      lat_cnt     <= lat_cnt_d;
      beat_cnt    <= beat_cnt_d;
      out_beat    <= out_beat_d;
      resp_o      <= resp_d;
      proto_err_o <= err_d;
    end
  end

  // Next-state and next-output logic; out_beat tracks the beat currently on resp_o.
  always_comb begin
    state_d    = state;
    op_write_d = op_write;
    line_idx_d = line_idx;
    lat_cnt_d  = lat_cnt;
    beat_cnt_d = beat_cnt;
    out_beat_d = out_beat;
    resp_d     = 1'b0;
    err_d      = proto_err_o;
    rd_en      = 1'b0;
    req_held   = op_write ? write_i : read_i;

    case (state)
      IDLE: begin
        if (read_i && write_i) begin
          err_d = 1'b1;
        end else if (read_i || write_i) begin
          op_write_d = write_i;
          line_idx_d = address_i[5 +: LINE_IDX_W];
          lat_cnt_d  = '0;
          beat_cnt_d = '0;
          state_d    = (LATENCY == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt + 4'd1;
          if (({1'b0, lat_cnt} + 5'd1) == 5'(LATENCY)) state_d = BURST;
        end
      end
      BURST: begin
        if (!req_held) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          resp_d     = 1'b1;
          out_beat_d = beat_cnt;
          rd_en      = !op_write;
          beat_cnt_d = beat_cnt + BEAT_IDX_W'(1);
          if (beat_cnt == BEAT_IDX_W'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!read_i && !write_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write beat only lands while the initiator still asserts write_i.
  assign wr_en = resp_o && op_write && write_i;

  burst_mem_array #(
    .ADDR_W(WORD_AW)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_en   (rd_en),
    .rd_addr ({line_idx, beat_cnt}),
    .wr_en   (wr_en),
    .wr_addr ({line_idx, out_beat}),
    .wr_data (burst_i),
    .rd_data (burst_o)
  );
endmodule

// File: tb/tb_burst_memory_responder.sv
// Directed bench for burst_memory_responder: transaction table plus reset, hold and error sequences.
module tb_burst_memory_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd4, wr4, rd0, wr0;
  logic [31:0] addr4, addr0;
  logic [63:0] din4, din0, dout4, dout0;
  logic        resp4, resp0, err4, err0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int           lat;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;

  localparam logic [255:0] D_A = {64'd4, 64'd3, 64'd2, 64'd1};
  localparam logic [255:0] D_B = {64'hB000_0000_0000_00B3, 64'hB000_0000_0000_00B2,
                                  64'hB000_0000_0000_00B1, 64'hB000_0000_0000_00B0};
  localparam logic [255:0] D_C = {64'hC3C3_C3C3_0000_0003, 64'hC2C2_C2C2_0000_0002,
                                  64'hC1C1_C1C1_0000_0001, 64'hC0C0_C0C0_0000_0000};
  localparam logic [255:0] D_D = {64'hDDDD_0000_0000_0004, 64'hDDDD_0000_0000_0003,
                                  64'hDDDD_0000_0000_0002, 64'hDDDD_0000_0000_0001};
  localparam logic [255:0] D_O = {64'h0000_0000_0000_0A03, 64'h0000_0000_0000_0A02,
                                  64'h0000_0000_0000_0A01, 64'h0000_0000_0000_0A00};
  localparam logic [255:0] D_N = {64'h0000_0000_0000_0E03, 64'h0000_0000_0000_0E02,
                                  64'h0000_0000_0000_0E01, 64'h0000_0000_0000_0E00};

  always #5 clk = ~clk;

  burst_memory_responder #(.LINE_IDX_W(6), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .read_i(rd4), .write_i(wr4), .address_i(addr4),
    .burst_i(din4), .burst_o(dout4), .resp_o(resp4), .proto_err_o(err4)
  );

  burst_memory_responder #(.LINE_IDX_W(6), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .read_i(rd0), .write_i(wr0), .address_i(addr0),
    .burst_i(din0), .burst_o(dout0), .resp_o(resp0), .proto_err_o(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int lat, input logic rd, input logic wr, input logic [31:0] a);
    if (lat == 0) begin rd0 = rd; wr0 = wr; addr0 = a; end
    else          begin rd4 = rd; wr4 = wr; addr4 = a; end
  endtask

  task automatic set_din(input int lat, input logic [63:0] d);
    if (lat == 0) din0 = d;
    else          din4 = d;
  endtask

  function automatic logic get_resp(input int lat);
    return (lat == 0) ? resp0 : resp4;
  endfunction

  function automatic logic [63:0] get_dout(input int lat);
    return (lat == 0) ? dout0 : dout4;
  endfunction

  // Full transaction: accept, latency, 4 beats, drop request one cycle after the last beat.
  task automatic run_txn(input vec_t v, input string tag);
    int n;
    int beats;
    set_req(v.lat, !v.wr, v.wr, v.addr);
    tick();
    n = 0;
    while (!get_resp(v.lat) && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("%s latency", tag), 64'(n), 64'(v.lat + 1));
    beats = 0;
    while (get_resp(v.lat) && beats < 8) begin
      if (beats < 4) begin
        set_din(v.lat, v.data[64*beats +: 64]);
        if (!v.wr)
          check($sformatf("%s beat%0d", tag, beats), get_dout(v.lat), v.exp[64*beats +: 64]);
      end
      beats++;
      tick();
    end
    check($sformatf("%s beat count", tag), 64'(beats), 64'd4);
    check($sformatf("%s idle data", tag), get_dout(v.lat), 64'd0);
    set_req(v.lat, 1'b0, 1'b0, v.addr);
    tick();
    tick();
  endtask

  vec_t vecs[12];

  initial begin
    vec_t v;
    int   n;
    int   cnt;

    vecs[0]  = '{4, 1'b1, 32'h0000_0040, D_A, '0};
    vecs[1]  = '{4, 1'b0, 32'h0000_0040, '0,  D_A};
    vecs[2]  = '{4, 1'b0, 32'h0000_005F, '0,  D_A};
    vecs[3]  = '{4, 1'b1, 32'h0000_0800, D_B, '0};
    vecs[4]  = '{4, 1'b0, 32'h0000_0000, '0,  D_B};
    vecs[5]  = '{4, 1'b1, 32'h0000_07E0, D_C, '0};
    vecs[6]  = '{4, 1'b0, 32'hFFFF_FFE0, '0,  D_C};
    vecs[7]  = '{4, 1'b1, 32'h0000_0040, D_D, '0};
    vecs[8]  = '{4, 1'b0, 32'h0000_0040, '0,  D_D};
    vecs[9]  = '{4, 1'b0, 32'h0000_0800, '0,  D_B};
    vecs[10] = '{0, 1'b1, 32'h0000_0020, D_C, '0};
    vecs[11] = '{0, 1'b0, 32'h0000_0020, '0,  D_C};

    reset_n = 1'b0;
    rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; din4 = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    repeat (3) tick();
    check("reset resp", 64'(resp4), 64'd0);
    check("reset data", dout4, 64'd0);
    check("reset err", 64'(err4), 64'd0);
    check("reset resp lat0", 64'(resp0), 64'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a read burst
    set_req(4, 1'b1, 1'b0, 32'h40);
    tick();
    n = 0;
    while (!resp4 && n < 40) begin tick(); n++; end
    tick();
    check("midburst resp before reset", 64'(resp4), 64'd1);
    reset_n = 1'b0;
    set_req(4, 1'b0, 1'b0, 32'h40);
    tick();
    check("midburst reset resp", 64'(resp4), 64'd0);
    check("midburst reset data", dout4, 64'd0);
    reset_n = 1'b1;
    tick();
    check("post reset idle resp", 64'(resp4), 64'd0);
    v = '{4, 1'b0, 32'h40, '0, D_D};
    run_txn(v, "after reset");

    // Request held after the last beat must not retrigger
    set_req(4, 1'b1, 1'b0, 32'h40);
    tick();
    n = 0;
    while (!resp4 && n < 40) begin tick(); n++; end
    cnt = 0;
    while (resp4 && cnt < 8) begin tick(); cnt++; end
    check("hold first burst beats", 64'(cnt), 64'd4);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp4) cnt++;
    end
    check("hold no rebust", 64'(cnt), 64'd0);
    set_req(4, 1'b0, 1'b0, 32'h40);
    tick();
    run_txn(v, "hold re-raise");

    // Both requests high in IDLE
    set_req(4, 1'b1, 1'b1, 32'h40);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp4) cnt++;
    end
    check("both high resp", 64'(cnt), 64'd0);
    check("both high err", 64'(err4), 64'd1);
    set_req(4, 1'b0, 1'b0, 32'h40);
    tick();
    check("err sticky", 64'(err4), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("err cleared", 64'(err4), 64'd0);

    // Write aborted after beat 1
    v = '{4, 1'b1, 32'h60, D_O, '0};
    run_txn(v, "abort prefill");
    set_req(4, 1'b0, 1'b1, 32'h60);
    tick();
    n = 0;
    while (!resp4 && n < 40) begin tick(); n++; end
    check("abort latency", 64'(n), 64'd5);
    din4 = D_N[63:0];
    tick();
    check("abort beat1 resp", 64'(resp4), 64'd1);
    din4 = D_N[127:64];
    tick();
    set_req(4, 1'b0, 1'b0, 32'h60);
    din4 = D_N[191:128];
    tick();
    check("abort resp", 64'(resp4), 64'd0);
    check("abort err", 64'(err4), 64'd1);
    tick();
    v = '{4, 1'b0, 32'h60, '0, {D_O[255:128], D_N[127:0]}};
    run_txn(v, "abort readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
